// File: rtl/accel_sample_scheduler.sv
// accel_sample_scheduler: configures the accelerometer over SPI, services sample
// ticks with a six-byte register burst, saturates each axis to 8 bits and
// publishes the set on the synchronised falling edge of vsync.
module accel_sample_scheduler #(
  parameter int unsigned PWRUP_CYCLES = 1_000_000,
  parameter int unsigned TIMEOUT      = 4096,
  parameter int unsigned SHIFT        = 2,
  parameter logic [7:0]  DATA_FORMAT  = 8'h01,
  parameter logic [7:0]  BW_RATE      = 8'h0A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_tick,
  input  logic       vsync,
  output logic       spi_start,
  output logic       spi_rw,
  output logic [5:0] spi_addr,
  output logic [7:0] spi_wdata,
  input  logic       spi_busy,
  input  logic       spi_done,
  input  logic [7:0] spi_rdata,
  output logic [7:0] ax,
  output logic [7:0] ay,
  output logic [7:0] az,
  output logic       data_valid,
  output logic       cfg_done,
  output logic       timeout_err
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [2:0] {
    S_PWRUP, S_CFG, S_IDLE, S_RD, S_CONV, S_HOLD, S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             xfer_q, xfer_d;
  logic             pend_q, pend_d;
  logic [5:0][7:0]  rx_q, rx_d;
  logic [7:0]       sh_x_q, sh_x_d, sh_y_q, sh_y_d, sh_z_q, sh_z_d;
  logic             start_q, start_d;
  logic             rw_q, rw_d;
  logic [5:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       ax_q, ax_d, ay_q, ay_d, az_q, az_d;
  logic             dv_q, dv_d;
  logic             cfg_done_q, cfg_done_d;
  logic             tmo_q, tmo_d;
  logic             vs_s1_q, vs_s2_q, vs_s3_q;
  logic             vs_fall_c;
  logic [5:0]       cfg_addr_c;
  logic [7:0]       cfg_data_c;

  // Arithmetic shift of the raw 16-bit value, then clamp to -128..127
  function automatic logic [7:0] sat8(input logic [15:0] raw);
    logic signed [15:0] s;
    s = $signed(raw) >>> SHIFT;
    if (s > 16'sd127)       sat8 = 8'h7F;
    else if (s < -16'sd128) sat8 = 8'h80;
    else                    sat8 = s[7:0];
  endfunction

  assign vs_fall_c = vs_s3_q & ~vs_s2_q;

  // Configuration write table indexed by step
  always_comb begin
    cfg_addr_c = 6'h31;
    cfg_data_c = DATA_FORMAT;
    case (idx_q)
      3'd1:    begin cfg_addr_c = 6'h2C; cfg_data_c = BW_RATE; end
      3'd2:    begin cfg_addr_c = 6'h2D; cfg_data_c = 8'h08;   end
      default: ;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    xfer_d     = xfer_q;
    pend_d     = pend_q;
    rx_d       = rx_q;
    sh_x_d     = sh_x_q;
    sh_y_d     = sh_y_q;
    sh_z_d     = sh_z_q;
    start_d    = 1'b0;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ax_d       = ax_q;
    ay_d       = ay_q;
    az_d       = az_q;
    dv_d       = 1'b0;
    cfg_done_d = cfg_done_q;
    tmo_d      = tmo_q;

    if (sample_tick && (state_q != S_IDLE)) pend_d = 1'b1;

    case (state_q)
      S_PWRUP: begin
        if (cnt_q == CNT_W'(PWRUP_CYCLES - 1)) begin
          state_d = S_CFG;
          cnt_d   = '0;
          idx_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CFG, S_RD: begin
        if (xfer_q) begin
          if (spi_done) begin
            xfer_d = 1'b0;
            if (state_q == S_RD) rx_d[idx_q] = spi_rdata;
            if ((state_q == S_CFG) && (idx_q == 3'd2)) begin
              state_d    = S_IDLE;
              idx_d      = 3'd0;
              cfg_done_d = 1'b1;
              tmo_d      = 1'b0;
            end else if ((state_q == S_RD) && (idx_q == 3'd5)) begin
              state_d = S_CONV;
              idx_d   = 3'd0;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            // Abandon the transaction; the partial burst is never converted
            xfer_d     = 1'b0;
            tmo_d      = 1'b1;
            cfg_done_d = 1'b0;
            idx_d      = 3'd0;
            state_d    = S_ERR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (!spi_busy) begin
          start_d = 1'b1;
          xfer_d  = 1'b1;
          cnt_d   = '0;
          if (state_q == S_CFG) begin
            rw_d    = 1'b0;
            addr_d  = cfg_addr_c;
            wdata_d = cfg_data_c;
          end else begin
            rw_d    = 1'b1;
            addr_d  = 6'h32 + 6'(idx_q);
            wdata_d = 8'h00;
          end
        end
      end
      S_IDLE: begin
        if (sample_tick || pend_q) begin
          state_d = S_RD;
          pend_d  = 1'b0;
          idx_d   = 3'd0;
          if (!spi_busy) begin
            start_d = 1'b1;
            xfer_d  = 1'b1;
            cnt_d   = '0;
            rw_d    = 1'b1;
            addr_d  = 6'h32;
            wdata_d = 8'h00;
          end
        end
      end
      S_CONV: begin
        sh_x_d  = sat8({rx_q[1], rx_q[0]});
        sh_y_d  = sat8({rx_q[3], rx_q[2]});
        sh_z_d  = sat8({rx_q[5], rx_q[4]});
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (vs_fall_c) begin
          ax_d    = sh_x_q;
          ay_d    = sh_y_q;
          az_d    = sh_z_q;
          dv_d    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        state_d = S_CFG;
        idx_d   = 3'd0;
      end
      default: state_d = S_PWRUP;
    endcase
  end

  // State and output registers; vsync passes through a 2-flop synchroniser plus edge register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_PWRUP;
      cnt_q      <= '0;
      idx_q      <= 3'd0;
      xfer_q     <= 1'b0;
      pend_q     <= 1'b0;
      rx_q       <= '0;
      sh_x_q     <= 8'h00;
      sh_y_q     <= 8'h00;
      sh_z_q     <= 8'h00;
      start_q    <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= 6'h00;
      wdata_q    <= 8'h00;
      ax_q       <= 8'h00;
      ay_q       <= 8'h00;
      az_q       <= 8'h00;
      dv_q       <= 1'b0;
      cfg_done_q <= 1'b0;
      tmo_q      <= 1'b0;
      vs_s1_q    <= 1'b1;
      vs_s2_q    <= 1'b1;
      vs_s3_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      xfer_q     <= xfer_d;
      pend_q     <= pend_d;
      rx_q       <= rx_d;
      sh_x_q     <= sh_x_d;
      sh_y_q     <= sh_y_d;
      sh_z_q     <= sh_z_d;
      start_q    <= start_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ax_q       <= ax_d;
      ay_q       <= ay_d;
      az_q       <= az_d;
      dv_q       <= dv_d;
      cfg_done_q <= cfg_done_d;
      tmo_q      <= tmo_d;
      vs_s1_q    <= vsync;
      vs_s2_q    <= vs_s1_q;
      vs_s3_q    <= vs_s2_q;
    end
  end

  assign spi_start   = start_q;
  assign spi_rw      = rw_q;
  assign spi_addr    = addr_q;
  assign spi_wdata   = wdata_q;
  assign ax          = ax_q;
  assign ay          = ay_q;
  assign az          = az_q;
  assign data_valid  = dv_q;
  assign cfg_done    = cfg_done_q;
  assign timeout_err = tmo_q;

endmodule
